// File: rtl/uart_bus_if.sv
// uart_bus_if: single-master peripheral bus driven by the UART bridge initiator
interface uart_bus_if;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;
  logic [3:0]  m_sel_o;
  logic        m_we_o;
  logic        m_rd_o;
  modport master (output m_addr_o, m_wdata_o, m_sel_o, m_we_o, m_rd_o, input m_rdata_i);
  modport slave  (input m_addr_o, m_wdata_o, m_sel_o, m_we_o, m_rd_o, output m_rdata_i);
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART 8N1 command frames to single 32-bit bus reads/writes with status/data reply
module uart_bus_bridge #(
  parameter int BAUD_DIV    = 434,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_pin,
  output logic      tx_pin,
  output logic      busy_o,
  uart_bus_if.master bus
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO      = TW'(TIMEOUT_CYC);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_ADDR = 3'd1;
  localparam logic [2:0] GET_DATA = 3'd2;
  localparam logic [2:0] BUS_WR   = 3'd3;
  localparam logic [2:0] BUS_RD   = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] REPLY    = 3'd6;
  logic          rx_s1, rx_s2, rx_d, rx_act, byte_valid, frame_err;
  logic [BW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [2:0]    st;
  logic          cmd_w;
  logic [1:0]    bcnt;
  logic [23:0]   addr_sh, data_sh;
  logic [TW-1:0] tcnt;
  logic [31:0]   rep;
  logic [2:0]    rep_n;
  logic          tx_act;
  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;
  logic          in_get;
  assign in_get = st == GET_ADDR || st == GET_DATA;
  assign busy_o = st != IDLE;
  // rx_bit 0 is the mid-start check, 1..8 data, 9 the stop sample that also re-arms
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rx_s1, rx_s2, rx_d} <= 3'b111;
      rx_act     <= 1'b0;
      rx_cnt     <= '0;
      rx_bit     <= 4'd0;
      rx_sh      <= 8'h0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx_pin;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!rx_act) begin
        rx_act <= rx_d & ~rx_s2;
        rx_cnt <= '0;
        rx_bit <= 4'd0;
      end else if (rx_cnt == (rx_bit == 4'd0 ? HALF_M1 : FULL_M1)) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) rx_act <= ~rx_s2;
        else if (rx_bit == 4'd9) begin
          rx_act     <= 1'b0;
          byte_valid <= rx_s2;
          frame_err  <= ~rx_s2;
        end else rx_sh <= {rx_s2, rx_sh[7:1]};
      end else rx_cnt <= rx_cnt + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st            <= IDLE;
      cmd_w         <= 1'b0;
      bcnt          <= 2'd0;
      addr_sh       <= 24'h0;
      data_sh       <= 24'h0;
      tcnt          <= '0;
      rep           <= 32'h0;
      rep_n         <= 3'd0;
      tx_act        <= 1'b0;
      tx_cnt        <= '0;
      tx_bit        <= 4'd0;
      tx_sh         <= 9'h1ff;
      tx_pin        <= 1'b1;
      bus.m_addr_o  <= 32'h0;
      bus.m_wdata_o <= 32'h0;
      bus.m_sel_o   <= 4'h0;
      bus.m_we_o    <= 1'b0;
      bus.m_rd_o    <= 1'b0;
    end else begin
      tcnt        <= (!in_get || byte_valid) ? '0 : (tcnt == TO ? tcnt : tcnt + 1'b1);
      bus.m_we_o  <= 1'b0;
      bus.m_rd_o  <= 1'b0;
      bus.m_sel_o <= 4'h0;
      case (st)
        IDLE:
          if (byte_valid) begin
            cmd_w <= rx_sh == 8'h57;
            bcnt  <= 2'd0;
            if (rx_sh == 8'h57 || rx_sh == 8'h52) st <= GET_ADDR;
            else begin
              st    <= REPLY;
              rep   <= 32'h45;
              rep_n <= 3'd1;
            end
          end
        GET_ADDR:
          if (byte_valid) begin
            addr_sh <= {rx_sh, addr_sh[23:8]};
            bcnt    <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              bus.m_addr_o <= {rx_sh, addr_sh};
              bcnt         <= 2'd0;
              if (cmd_w) st <= GET_DATA;
              else begin
                st          <= BUS_RD;
                bus.m_rd_o  <= 1'b1;
                bus.m_sel_o <= 4'hF;
              end
            end
          end else if (frame_err || tcnt == TO) st <= IDLE;
        GET_DATA:
          if (byte_valid) begin
            data_sh <= {rx_sh, data_sh[23:8]};
            bcnt    <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              st            <= BUS_WR;
              bus.m_wdata_o <= {rx_sh, data_sh};
              bus.m_we_o    <= 1'b1;
              bus.m_sel_o   <= 4'hF;
            end
          end else if (frame_err || tcnt == TO) st <= IDLE;
        BUS_WR: begin
          st    <= REPLY;
          rep   <= 32'h4B;
          rep_n <= 3'd1;
        end
        BUS_RD: st <= RD_WAIT;
        RD_WAIT: begin
          st    <= REPLY;
          rep   <= bus.m_rdata_i;
          rep_n <= 3'd4;
        end
        REPLY:
          // a new byte is loaded on entry and at the end of each stop bit, so bytes run back-to-back
          if (!tx_act || (tx_cnt == FULL_M1 && tx_bit == 4'd9 && rep_n != 3'd0)) begin
            tx_act <= 1'b1;
            tx_pin <= 1'b0;
            tx_sh  <= {1'b1, rep[7:0]};
            rep    <= {8'h0, rep[31:8]};
            rep_n  <= rep_n - 3'd1;
            tx_cnt <= '0;
            tx_bit <= 4'd0;
          end else if (tx_cnt != FULL_M1) tx_cnt <= tx_cnt + 1'b1;
          else if (tx_bit != 4'd9) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + 4'd1;
            tx_pin <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
          end else begin
            tx_act <= 1'b0;
            tx_cnt <= '0;
            st     <= IDLE;
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed frames with a bus/TX scoreboard for uart_bus_bridge
module tb_uart_bus_bridge;
  localparam int BD = 16;
  localparam int TO = 2000;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} bus_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_pin = 1'b1;
  logic tx_pin, busy_o;
  logic [31:0] rd_val = 32'h0;
  bus_t exp_bus[$];
  logic [7:0] exp_tx[$];
  int tx_starts[$];
  int compared = 0;
  int mismatched = 0;
  int epoch = 0;
  uart_bus_if bus ();
  uart_bus_bridge #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .tx_pin(tx_pin), .busy_o(busy_o), .bus(bus.master)
  );
  always #5 clk = ~clk;
  // registered slave: read data valid only in the cycle after m_rd_o
  always @(posedge clk) bus.m_rdata_i <= bus.m_rd_o ? rd_val : 32'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    bus_t e;
    if (rst_n && (bus.m_we_o || bus.m_rd_o)) begin
      if (exp_bus.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL bus unexpected strobe: got we=%b rd=%b addr=%h expected none", bus.m_we_o, bus.m_rd_o, bus.m_addr_o);
      end else begin
        e = exp_bus.pop_front();
        chk("bus we", bus.m_we_o, e.we);
        chk("bus rd", bus.m_rd_o, !e.we);
        chk("bus addr", bus.m_addr_o, e.addr);
        chk("bus sel", bus.m_sel_o, 4'hF);
        if (e.we) chk("bus wdata", bus.m_wdata_o, e.wdata);
      end
    end
  end
  initial forever begin
    int e;
    logic [7:0] b;
    logic s0, sp;
    @(negedge tx_pin);
    if (rst_n) begin
      e = epoch;
      tx_starts.push_back(int'($time / 10));
      repeat (BD / 2) @(negedge clk);
      s0 = tx_pin;
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = tx_pin;
      end
      repeat (BD) @(negedge clk);
      sp = tx_pin;
      if (e == epoch) begin
        chk("tx start bit", s0, 1'b0);
        chk("tx stop bit", sp, 1'b1);
        if (exp_tx.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL tx unexpected byte: got %h expected none", b);
        end else chk("tx byte", b, exp_tx.pop_front());
      end
    end
  end
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx_pin = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (BD) @(negedge clk);
    end
    rx_pin = stop;
    repeat (BD) @(negedge clk);
    rx_pin = 1'b1;
  endtask
  task automatic write_frame(input logic [31:0] a, input logic [31:0] d);
    exp_bus.push_back('{1'b1, a, d});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i+:8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i+:8]);
  endtask
  task automatic read_frame(input logic [31:0] a, input logic [31:0] v);
    rd_val = v;
    exp_bus.push_back('{1'b0, a, 32'h0});
    for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i+:8]);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(a[8*i+:8]);
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 50 * BD + 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(name, busy_o, 1'b0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " tx_pin"}, tx_pin, 1'b1);
    chk({tag, " busy"}, busy_o, 1'b0);
    chk({tag, " we"}, bus.m_we_o, 1'b0);
    chk({tag, " rd"}, bus.m_rd_o, 1'b0);
    chk({tag, " sel"}, bus.m_sel_o, 4'h0);
    chk({tag, " addr"}, bus.m_addr_o, 32'h0);
    chk({tag, " wdata"}, bus.m_wdata_o, 32'h0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h57);
    chk("busy after cmd", busy_o, 1'b1);
    exp_bus.push_back('{1'b1, 32'h10, 32'hDEADBEEF});
    exp_tx.push_back(8'h4B);
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'h10 : 8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_idle("write idle");
    read_frame(32'h08, 32'h0001C200);
    wait_idle("read idle");
    n = tx_starts.size();
    for (int k = 1; k < 4; k++) chk("tx byte spacing", tx_starts[n-k] - tx_starts[n-k-1], 10 * BD);
    exp_tx.push_back(8'h45);
    send_byte(8'h33);
    wait_idle("bad cmd idle");
    read_frame(32'h0000_0104, 32'hA5C3_0F1E);
    wait_idle("after bad cmd idle");
    send_byte(8'h57);
    send_byte(8'h10);
    chk("busy mid frame", busy_o, 1'b1);
    repeat (TO + 10) @(negedge clk);
    chk("timeout busy", busy_o, 1'b0);
    read_frame(32'h08, 32'h0001C200);
    wait_idle("after timeout idle");
    send_byte(8'h52);
    send_byte(8'h10);
    send_byte(8'hAA, 1'b0);
    repeat (2) @(negedge clk);
    chk("framing drop busy", busy_o, 1'b0);
    rx_pin = 1'b0;
    repeat (BD / 2 - 3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (12 * BD) @(negedge clk);
    chk("glitch busy", busy_o, 1'b0);
    read_frame(32'h1234_5678, 32'h8765_4321);
    wait_idle("after framing idle");
    read_frame(32'h20, 32'h1122_3344);
    repeat (230) @(negedge clk);
    chk("busy in reply", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    epoch++;
    #1 chk_reset("mid-reply reset");
    exp_tx.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (BD * 12) @(negedge clk);
    write_frame(32'h10, 32'hDEADBEEF);
    wait_idle("recovery idle");
    repeat (BD * 2) @(negedge clk);
    chk("bus queue drained", exp_bus.size(), 0);
    chk("tx queue drained", exp_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 100000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
